// File: rtl/tpu_pkg.sv
// Shared types and helpers for the TPU operand path.
// Feeder FSM states, default sizes and a lane slicer.
package tpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } feeder_state_t;

    localparam int DEF_N         = 16;
    localparam int DEF_OP_WIDTH  = 8;
    localparam int DEF_ACC_WIDTH = 32;

    // Widest lane / vector the slicer handles.
    localparam int LANE_MAX_W = 32;
    localparam int VEC_MAX_W  = 64 * LANE_MAX_W;

    // Return lane idx of a packed vector whose lanes are width bits.
    // Caller truncates the result to its own lane width.
    function automatic logic [LANE_MAX_W-1:0] lane(
        input logic [VEC_MAX_W-1:0] vec,
        input int                   idx,
        input int                   width
    );
        logic [VEC_MAX_W-1:0] sh;
        sh = vec >> (idx * width);
        return sh[LANE_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/operand_bank.sv
// N x N operand storage with a row write port.
// Skewed read returns the lanes for beat t of the systolic stream.
module operand_bank
    import tpu_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int OP_WIDTH  = DEF_OP_WIDTH,
    parameter int CW        = 6,
    parameter bit TRANSPOSE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [$clog2(N)-1:0]  wr_row,
    input  logic [N*OP_WIDTH-1:0] wr_data,
    input  logic [CW-1:0]         beat,
    output logic [N*OP_WIDTH-1:0] beat_data
);

    localparam int RW = $clog2(N);

    // mem[r][c]: row r, column c as written.
    logic [OP_WIDTH-1:0] mem [N][N];

    // Row write; reset zeroes the whole bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int c = 0; c < N; c++) begin
                mem[wr_row][c] <=
                    OP_WIDTH'(lane(VEC_MAX_W'(wr_data), c, OP_WIDTH));
            end
        end
    end

    // Skewed read: lane p carries inner index k = beat - p, else zero.
    // Row-major gives A[p][k]; transposed gives B[k][p].
    always_comb begin
        int k;
        k = 0;
        beat_data = '0;
        for (int p = 0; p < N; p++) begin
            k = int'(beat) - p;
            if (k >= 0 && k < N) begin
                if (TRANSPOSE) begin
                    beat_data[p*OP_WIDTH +: OP_WIDTH] = mem[k[RW-1:0]][p];
                end else begin
                    beat_data[p*OP_WIDTH +: OP_WIDTH] = mem[p][k[RW-1:0]];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Operand staging and diagonal skew in front of the MAC array.
// Streams A columns / B rows after start and flags done on the final accumulate.
module systolic_feeder
    import tpu_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int OP_WIDTH    = DEF_OP_WIDTH,
    parameter int MAC_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [$clog2(N)-1:0]  wr_row,
    input  logic [N*OP_WIDTH-1:0] wr_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [N*OP_WIDTH-1:0] next_a_column,
    output logic [N*OP_WIDTH-1:0] next_b_row
);

    localparam int CW = $clog2(3 * N + MAC_LATENCY + 1);
    localparam int VW = N * OP_WIDTH;

    // Counter value on the edge that loads the last beat.
    localparam logic [CW-1:0] LAST_BEAT = CW'(2 * N - 2);
    // Counter value on the edge of the final accumulate.
    localparam logic [CW-1:0] LAST_DRAIN = CW'(3 * N - 2 + MAC_LATENCY);

    feeder_state_t state_q;
    feeder_state_t state_d;

    logic [CW-1:0] cnt_q;
    logic          a_we;
    logic          b_we;
    logic [VW-1:0] a_beat;
    logic [VW-1:0] b_beat;

    operand_bank #(
        .N         (N),
        .OP_WIDTH  (OP_WIDTH),
        .CW        (CW),
        .TRANSPOSE (1'b0)
    ) u_bank_a (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (a_we),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .beat      (cnt_q),
        .beat_data (a_beat)
    );

    operand_bank #(
        .N         (N),
        .OP_WIDTH  (OP_WIDTH),
        .CW        (CW),
        .TRANSPOSE (1'b1)
    ) u_bank_b (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (b_we),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .beat      (cnt_q),
        .beat_data (b_beat)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a write in the same cycle wins over start.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !wr_en) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (cnt_q == LAST_BEAT) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == LAST_DRAIN) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Cycles since the accepting edge; held at zero while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Beat registers: load the skewed read while streaming, else zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_a_column <= '0;
            next_b_row    <= '0;
        end else if (state_q == ST_STREAM) begin
            next_a_column <= a_beat;
            next_b_row    <= b_beat;
        end else begin
            next_a_column <= '0;
            next_b_row    <= '0;
        end
    end

    // Status flags and bank write enables (writes only when idle).
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
        a_we = wr_en && (state_q == ST_IDLE) && !wr_sel;
        b_we = wr_en && (state_q == ST_IDLE) && wr_sel;
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder at N=4: beat-by-beat skew checks and a
// downstream MAC array model whose accumulators are compared to A*B.
module tb_systolic_feeder;

    localparam int N   = 4;
    localparam int OPW = 8;
    localparam int ML  = 1;
    localparam int VW  = N * OPW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [1:0]    wr_row = '0;
    logic [VW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [VW-1:0] next_a_column;
    logic [VW-1:0] next_b_row;

    systolic_feeder #(
        .N           (N),
        .OP_WIDTH    (OPW),
        .MAC_LATENCY (ML)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_sel        (wr_sel),
        .wr_row        (wr_row),
        .wr_data       (wr_data),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .next_a_column (next_a_column),
        .next_b_row    (next_b_row)
    );

    always #5 clk = ~clk;

    // Matrix contents the bank should hold, and expected accumulators.
    int A [N][N];
    int B [N][N];
    int Cexp [N][N];

    // Downstream array: a shifts right, b shifts down, acc += a*b.
    int ar [N][N];
    int br [N][N];
    int acc [N][N];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    ar[i][j]  <= 0;
                    br[i][j]  <= 0;
                    acc[i][j] <= 0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= acc[i][j] + ar[i][j] * br[i][j];
                end
            end
            for (int i = 0; i < N; i++) begin
                ar[i][0] <= int'($signed(next_a_column[i*OPW +: OPW]));
                for (int j = 1; j < N; j++) ar[i][j] <= ar[i][j-1];
            end
            for (int j = 0; j < N; j++) begin
                br[0][j] <= int'($signed(next_b_row[j*OPW +: OPW]));
                for (int i = 1; i < N; i++) br[i][j] <= br[i-1][j];
            end
        end
    end

    function automatic logic [VW-1:0] row_of(input bit sel, input int r);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            v[k*OPW +: OPW] = sel ? 8'(B[r][k]) : 8'(A[r][k]);
        end
        return v;
    endfunction

    // Beat t: A lane i = A[i][t-i], B lane j = B[t-j][j], else 0.
    function automatic logic [VW-1:0] exp_a(input int t);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (t - i >= 0 && t - i < N) v[i*OPW +: OPW] = 8'(A[i][t-i]);
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] exp_b(input int t);
        logic [VW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) begin
            if (t - j >= 0 && t - j < N) v[j*OPW +: OPW] = 8'(B[t-j][j]);
        end
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                A[i][j] = 0;
                B[i][j] = 0;
                Cexp[i][j] = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    task automatic write_row(input bit sel, input int r);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = 2'(r);
        wr_data = row_of(sel, r);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_all();
        for (int s = 0; s < 2; s++) begin
            for (int r = 0; r < N; r++) write_row(s[0], r);
        end
    endtask

    // One full run from start to the cycle after done.
    task automatic run(input bit wr_busy, input bit st_busy);
        int busy_n;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                for (int k = 0; k < N; k++) begin
                    Cexp[i][j] += A[i][k] * B[k][j];
                end
            end
        end
        busy_n = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int m = 0; m <= 3 * N + ML; m++) begin
            @(negedge clk);
            if (m == 0) start = 1'b0;
            wr_en = 1'b0;
            if (m == 4) start = 1'b0;
            if (busy) busy_n++;
            check("busy", 64'(busy), 64'(m <= 3 * N - 1 + ML));
            check("done", 64'(done), 64'(m == 3 * N - 1 + ML));
            check("a_beat", 64'(next_a_column),
                  (m >= 1 && m <= 2 * N - 1) ? 64'(exp_a(m - 1)) : 64'(0));
            check("b_beat", 64'(next_b_row),
                  (m >= 1 && m <= 2 * N - 1) ? 64'(exp_b(m - 1)) : 64'(0));
            if (m == 3 * N - 1 + ML) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        check($sformatf("c%0d%0d", i, j), 64'(acc[i][j]),
                              64'(Cexp[i][j]));
                    end
                end
            end
            if (wr_busy && m == 2) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_row  = 2'd0;
                wr_data = {N{8'd9}};
            end
            if (st_busy && m == 3) start = 1'b1;
        end
        check("busy_len", 64'(busy_n), 64'(3 * N + ML));
    endtask

    initial begin
        clear_model();
        #2 reset = 1'b1;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_a", 64'(next_a_column), 64'(0));
        check("rst_b", 64'(next_b_row), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // Identity times B: C equals B, C[3][3] = 16.
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                A[i][j] = (i == j) ? 1 : 0;
                B[i][j] = 4 * i + j + 1;
            end
        end
        load_all();
        run(1'b0, 1'b0);
        check("c33_is_16", 64'(acc[3][3]), 64'(16));

        // All 2 times all 3: every C = 24.
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                A[i][j] = 2;
                B[i][j] = 3;
            end
        end
        load_all();
        run(1'b0, 1'b0);
        check("c00_is_24", 64'(acc[0][0]), 64'(24));

        // Signed lanes: -1 times 127 gives -508.
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                A[i][j] = -1;
                B[i][j] = 127;
            end
        end
        load_all();
        run(1'b0, 1'b0);
        check("c21_neg", 64'(acc[2][1]), 64'(-508));

        // Write while busy is dropped; a later idle write lands.
        run(1'b1, 1'b0);
        for (int k = 0; k < N; k++) A[0][k] = 9;
        write_row(1'b0, 0);
        run(1'b0, 1'b0);

        // start with wr_en: write taken, no run.
        @(negedge clk);
        for (int k = 0; k < N; k++) A[1][k] = 5;
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_row  = 2'd1;
        wr_data = row_of(1'b0, 1);
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        check("st_wr_busy", 64'(busy), 64'(0));
        @(negedge clk);
        check("st_wr_busy2", 64'(busy), 64'(0));

        // start during streaming is ignored.
        run(1'b0, 1'b1);

        // Reset at beat 3.
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                A[i][j] = i + 2 * j + 1;
                B[i][j] = 3 * i - j;
            end
        end
        load_all();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_a", 64'(next_a_column), 64'(exp_a(3)));
        #1 reset = 1'b1;
        #1;
        check("mid_rst_a", 64'(next_a_column), 64'(0));
        check("mid_rst_b", 64'(next_b_row), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        run(1'b0, 1'b0);

        // Random operands, accumulating across back-to-back runs.
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    A[i][j] = int'($urandom_range(0, 255)) - 128;
                    B[i][j] = int'($urandom_range(0, 255)) - 128;
                end
            end
            load_all();
            run(1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
